// File: rtl/addsub_pkg.sv
// Shared definitions for the round-robin add/subtract arbiter: FSM encoding,
// op encoding and the signed-overflow rule.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Overflow when the effective operand signs agree but the result sign differs.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic sub, input logic sum_msb);
    return (x_msb == (y_msb ^ sub)) && (sum_msb != x_msb);
  endfunction

endpackage

// File: rtl/adder_subtractor_nbit.sv
// Ripple-carry adder/subtractor: add_n selects x - y (two's complement via
// inverted y and carry-in) or x + y.
module adder_subtractor_nbit
  import addsub_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n:0]   c;
  logic [n-1:0] yb;

  assign yb   = y ^ {n{add_n == OP_SUB}};
  assign c[0] = add_n;

  for (genvar i = 0; i < n; i++) begin : g_fa
    assign sum[i]   = x[i] ^ yb[i] ^ c[i];
    assign c[i+1]   = (x[i] & yb[i]) | (c[i] & (x[i] ^ yb[i]));
  end

  assign cout = c[n];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that time-shares one adder/subtractor among NREQ
// requesters and returns a registered, id-tagged result.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int n    = 4,
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*n-1:0] req_x,
  input  logic [NREQ*n-1:0] req_y,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [n-1:0]      rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_ovf
);

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, id_q;
  logic [n-1:0]   x_q, y_q, rsp_sum_q;
  logic           sub_q, rsp_cout_q, rsp_ovf_q;

  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           hs;
  logic [n-1:0]   dp_sum;
  logic           dp_cout;

  // Search upward from last+1 with wrap; iterating from the far end lets the
  // nearest valid requester win.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign hs = (state_q == IDLE) && gnt_any;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
    rsp_valid = (state_q == RESP);
  end

  adder_subtractor_nbit #(.n(n)) u_addsub (
    .x     (x_q),
    .y     (y_q),
    .add_n (sub_q),
    .sum   (dp_sum),
    .cout  (dp_cout)
  );

  always_ff @(posedge clk) begin
    if (hs) begin
      x_q   <= req_x[gnt_idx*n +: n];
      y_q   <= req_y[gnt_idx*n +: n];
      sub_q <= req_sub[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= IDW'(NREQ - 1);
      id_q       <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      if (hs) begin
        last_q <= gnt_idx;
        id_q   <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_sum_q  <= dp_sum;
        rsp_cout_q <= dp_cout;
        rsp_ovf_q  <= signed_ovf(x_q[n-1], y_q[n-1], sub_q, dp_sum[n-1]);
      end
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = rsp_sum_q;
  assign rsp_cout = rsp_cout_q;
  assign rsp_ovf  = rsp_ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed and randomized bench for addsub_arbiter against an arithmetic
// and round-robin reference model.
module tb_addsub_arbiter;

  localparam int N    = 4;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_x;
  logic [NREQ*N-1:0] req_y;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_cout;
  logic              rsp_ovf;

  int total = 0;
  int bad   = 0;
  int m_last;

  addsub_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    return -1;
  endfunction

  // Plain integer arithmetic: unsigned result/carry and signed range check.
  function automatic void m_arith(input int x, input int y, input int sub,
                                  output int s, output int c, output int o);
    int sx, sy, r, sr;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    if (sub != 0) begin
      r  = x - y;
      c  = (x >= y) ? 1 : 0;
      sr = sx - sy;
    end else begin
      r  = x + y;
      c  = (r >= 16) ? 1 : 0;
      sr = sx + sy;
    end
    s = (r + 32) % 16;
    o = (sr < -8 || sr > 7) ? 1 : 0;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_last = NREQ - 1;
  endtask

  task automatic txn(input logic [1:0] vm,
                     input logic [3:0] x0, input logic [3:0] y0, input logic s0,
                     input logic [3:0] x1, input logic [3:0] y1, input logic s1,
                     input int bp);
    int g, es, ec, eo;
    logic [3:0] ex, ey;
    logic esub;
    req_valid = vm;
    req_x     = {x1, x0};
    req_y     = {y1, y0};
    req_sub   = {s1, s0};
    rsp_ready = (bp == 0);
    #1;
    g = m_grant(vm);
    chk("idle_ready", req_ready, 32'(1) << g);
    chk("idle_rsp_valid", rsp_valid, 0);
    ex   = (g == 1) ? x1 : x0;
    ey   = (g == 1) ? y1 : y0;
    esub = (g == 1) ? s1 : s0;
    m_arith(ex, ey, esub, es, ec, eo);
    @(posedge clk);
    #1;
    m_last    = g;
    req_x     = ~req_x;
    req_y     = 8'($urandom);
    req_sub   = ~req_sub;
    req_valid = 2'b11;
    #1;
    chk("exec_ready", req_ready, 0);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, g);
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_cout", rsp_cout, ec);
    chk("rsp_ovf", rsp_ovf, eo);
    chk("resp_ready", req_ready, 0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, es);
      chk("bp_id", rsp_id, g);
      chk("bp_cout_ovf", {rsp_cout, rsp_ovf}, {ec[0], eo[0]});
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    chk("done_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    do_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outs", {rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 0);

    // Add with overflow, subtract both directions
    txn(2'b01, 4'd5, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0, 0);
    txn(2'b10, 4'd0, 4'd0, 1'b0, 4'd5, 4'd3, 1'b1, 0);
    txn(2'b10, 4'd0, 4'd0, 1'b0, 4'd3, 4'd5, 1'b1, 0);

    // Simultaneous requests after reset: alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, 4'(i), 4'd2, 1'b0, 4'(i + 7), 4'd1, 1'b1, 0);
      chk("alt_grant", rsp_id, i % 2);
    end

    // Back-pressure for 5 cycles
    txn(2'b11, 4'd9, 4'd9, 1'b0, 4'd6, 4'd7, 1'b1, 5);

    // Reset during EXEC: no response, req0 priority afterwards
    txn(2'b01, 4'd1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 0);
    req_valid = 2'b01;
    req_x     = {4'd2, 4'd7};
    req_y     = {4'd2, 4'd7};
    req_sub   = 2'b00;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_last = NREQ - 1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_outs", {rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    txn(2'b11, 4'd4, 4'd4, 1'b0, 4'd1, 4'd1, 1'b0, 0);
    chk("post_rst_grant0", rsp_id, 0);

    // Wrap-around arithmetic
    txn(2'b10, 4'd0, 4'd0, 1'b0, 4'd15, 4'd1, 1'b0, 0);
    txn(2'b01, 4'd8, 4'd1, 1'b1, 4'd0, 4'd0, 1'b0, 0);

    // Randomized traffic with idle gaps and back-pressure
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        #1;
        chk("gap_ready", req_ready, 0);
        @(posedge clk);
        #1;
        chk("gap_rsp_valid", rsp_valid, 0);
      end
      txn(2'($urandom_range(1, 3)),
          4'($urandom), 4'($urandom), 1'($urandom),
          4'($urandom), 4'($urandom), 1'($urandom),
          int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
